mont_ladder_exp_p: RTL and testbench
====================================

Name: mont_ladder_exp_p

Overview:
Parametrised Montgomery-ladder modular exponentiation controller: result = x^e mod m. Drives two external Montgomery multiplier channels concurrently: ch0 computes the ladder product, ch1 the ladder square. Adds width/length parameters, busy/error reporting, abort and a request/response multiplier interface. Sits between the RSA top-level control FSM and the multiplier instances.

Parameters:
WIDTH, 1024, operand/modulus width in bits; Montgomery R = 2^WIDTH
ELEN_W, 32, width of the exponent-length input

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
start  in  1  one-cycle request; sampled only in IDLE
abort  in  1  return to IDLE from any state; no done
in_x  in  WIDTH  base, < in_m
in_m  in  WIDTH  odd modulus
in_e  in  WIDTH  exponent, right-aligned
in_lene  in  ELEN_W  number of exponent bits to process, 0..WIDTH
in_r  in  WIDTH  R mod m
in_r2  in  WIDTH  R^2 mod m
mul_start  out  2  per-channel one-cycle issue pulse
mul_a0, mul_b0, mul_a1, mul_b1  out  WIDTH each  channel operands
mul_res0, mul_res1  in  WIDTH each  channel results, valid with mul_done
mul_done  in  2  per-channel one-cycle completion pulse
result  out  WIDTH  x^e mod m (normal domain)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, result valid
err  out  1  high for one cycle when in_lene > WIDTH; no operation started

Behaviour:
- Reset: state IDLE; result, mul_start, busy, done, err = 0; R0/R1/E/bit counter cleared.
- Inputs captured at start acceptance; in_x/in_m/in_e/in_r/in_r2/in_lene registered; they may change afterwards.
- Operands held stable from issue until the channel's mul_done; mul_res sampled only in the mul_done cycle.
- mul_done per channel latched into done flags; round completes when all issued channels are done; arrival order and skew are arbitrary; flags cleared on every issue.
- States:
  IDLE: on start with in_lene > WIDTH -> err pulse, stay. Otherwise load R0 = in_r, cnt = in_lene -> ISSUE_INIT.
  ISSUE_INIT: pulse ch0 with (x, r2) -> WAIT_INIT.
  WAIT_INIT: on ch0 done R1 = res0 -> ISSUE if cnt > 0, else FINAL_ISSUE.
  ISSUE: bit b = e[cnt-1]; pulse both. b=1: ch0 = (R0,R1), ch1 = (R1,R1). b=0: ch0 = (R0,R1), ch1 = (R0,R0) -> WAIT.
  WAIT: on both done: b=1 R0 = res0, R1 = res1; b=0 R1 = res0, R0 = res1; cnt -= 1 -> ISSUE if cnt > 0, else FINAL_ISSUE.
  FINAL_ISSUE: pulse ch0 with (R0, 1) -> FINAL_WAIT.
  FINAL_WAIT: on ch0 done result = res0 -> DONE.
  DONE: done = 1 for one cycle -> IDLE.
- result holds until the next accepted start completes.
- Timing: multiplier latency L (done L cycles after issue); start sampled in cycle 0; done in cycle 1 + (lene+2)(L+1).
- start while busy: ignored.
- abort: highest priority. IDLE next cycle; mul_start deasserted; late mul_done pulses ignored; result unchanged.
- in_lene = 0: result = 1 (R0 = R, final multiply by 1).
- resetn low mid-operation: same as reset.

Optional Feature:
MONT_LADDER_SKIP_ZERO_EN
- Defined: state SKIP after ISSUE_INIT; while cnt > 0 and e[cnt-1] = 0, cnt -= 1 at one cycle per bit, no multiplies. Result is identical. Latency is data-dependent (not constant-time).
- Undefined: all in_lene bits go through the ladder; latency depends only on in_lene and L.

Decomposition:
- Package mont_exp_pkg: state enum, channel index constants CH_MUL = 0 / CH_SQR = 1.
- Sub-module mont_done_latch: per-channel done flag with clear-on-issue and all-done output; instantiated once with 2 channels.

Test Plan:
(Bench multiplier model: WIDTH = 16, fixed L = 5, computes a*b*R^-1 mod m.)
- m=7, x=3, e=5, lene=3, r=2, r2=4 -> result = 5; done in cycle 31; busy high for cycles 1..31.
- Same operands, lene=0 -> result = 1; lene=1, e=1 -> result = 3.
- lene=17 -> err pulse; busy stays 0; no mul_start.
- Second start while busy -> ignored; single done; result unchanged from the first run.
- abort in WAIT of round 2 -> IDLE next cycle; no done; a following run yields the correct result.
- Skew: ch1 done 3 cycles after ch0 -> correct result, with latency extended by 3 per round. With MONT_LADDER_SKIP_ZERO_EN, e=5 and lene=8 -> result = 5 and 5 skip cycles.

Source files
------------

// File: rtl/mont_exp_pkg.sv
// Shared types and constants for the Montgomery-ladder exponentiation controller.
//   state_e : controller FSM states
//   CH_MUL  : multiplier channel carrying the ladder product
//   CH_SQR  : multiplier channel carrying the ladder square
package mont_exp_pkg;

  localparam int unsigned N_CH   = 2;
  localparam int unsigned CH_MUL = 0;
  localparam int unsigned CH_SQR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ISSUE_INIT,
    ST_SKIP,
    ST_WAIT_INIT,
    ST_ISSUE,
    ST_WAIT,
    ST_FINAL_ISSUE,
    ST_FINAL_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mont_ladder_exp_p_if.sv
// Request/response bus between the ladder controller and two Montgomery multipliers.
//   mul_start : per-channel one-cycle issue pulse (controller -> multiplier)
//   mul_a0/b0 : channel 0 operands, mul_a1/b1 : channel 1 operands
//   mul_res0/1: channel results, valid in the cycle mul_done is high
//   mul_done  : per-channel one-cycle completion pulse (multiplier -> controller)
interface mont_ladder_exp_p_if
  import mont_exp_pkg::*;
#(
  parameter int unsigned WIDTH = 1024
);

  logic [N_CH-1:0]  mul_start;
  logic [WIDTH-1:0] mul_a0;
  logic [WIDTH-1:0] mul_b0;
  logic [WIDTH-1:0] mul_a1;
  logic [WIDTH-1:0] mul_b1;
  logic [WIDTH-1:0] mul_res0;
  logic [WIDTH-1:0] mul_res1;
  logic [N_CH-1:0]  mul_done;

  modport master (
    output mul_start, mul_a0, mul_b0, mul_a1, mul_b1,
    input  mul_res0, mul_res1, mul_done
  );

  modport slave (
    input  mul_start, mul_a0, mul_b0, mul_a1, mul_b1,
    output mul_res0, mul_res1, mul_done
  );

endinterface

// File: rtl/mont_done_latch.sv
// Per-channel completion flags for one multiplier round.
//   clk, resetn  : clock, synchronous active-low reset
//   i_clr        : issue cycle; drops all flags
//   i_done       : per-channel completion pulses
//   i_mask       : channels that belong to the current round
//   o_all_done_c : every masked channel has completed (includes this cycle's pulses)
module mont_done_latch #(
  parameter int unsigned N_CH = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_clr,
  input  logic [N_CH-1:0] i_done,
  input  logic [N_CH-1:0] i_mask,
  output logic            o_all_done_c
);

  logic [N_CH-1:0] r_flag;

  // Sticky flags so channels may finish in any order and with any skew
  always_ff @(posedge clk) begin
    if (!resetn)    r_flag <= '0;
    else if (i_clr) r_flag <= '0;
    else            r_flag <= r_flag | i_done;
  end

  assign o_all_done_c = &(r_flag | i_done | ~i_mask);

endmodule

// File: rtl/mont_ladder_exp_p.sv
// Montgomery-ladder modular exponentiation controller: result = x^e mod m.
// Channel 0 computes the ladder product, channel 1 the ladder square, concurrently.
// Optional build macro MONT_LADDER_SKIP_ZERO_EN: skip leading zero exponent bits
// at one cycle per bit (latency becomes data dependent).
//   clk, resetn      : clock, synchronous active-low reset
//   start, abort     : request pulse (IDLE only) / return to IDLE from anywhere
//   in_x/m/e/r/r2    : base, modulus, exponent, R mod m, R^2 mod m
//   in_lene          : number of exponent bits to process (0..WIDTH)
//   result           : x^e mod m, held until the next completed run
//   busy, done, err  : not idle / one-cycle completion / one-cycle bad length
//   mul              : multiplier bus (master side)
module mont_ladder_exp_p
  import mont_exp_pkg::*;
#(
  parameter int unsigned WIDTH  = 1024,
  parameter int unsigned ELEN_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    in_x,
  input  logic [WIDTH-1:0]    in_m,
  input  logic [WIDTH-1:0]    in_e,
  input  logic [ELEN_W-1:0]   in_lene,
  input  logic [WIDTH-1:0]    in_r,
  input  logic [WIDTH-1:0]    in_r2,
  output logic [WIDTH-1:0]    result,
  output logic                busy,
  output logic                done,
  output logic                err,
  mont_ladder_exp_p_if.master mul
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e            r_state, w_state_n;
  logic [WIDTH-1:0]  r_x, r_e, r_r2, r_r0, r_r1, r_res0, r_res1, r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic [N_CH-1:0]   r_mul_start;
  logic              r_busy, r_done, r_err;

  logic [WIDTH-1:0]  w_res0, w_res1, w_a0, w_b0, w_sq;
  logic [CNT_W-1:0]  w_cnt_m1;
  logic              w_bit, w_all_done;
  logic              w_load, w_err, w_init_r1, w_round, w_final, w_dec;
  logic [N_CH-1:0]   w_issue_mask, w_wait_mask;
  logic              w_unused_m;

  // The modulus is consumed by the multiplier instances, not by the ladder
  assign w_unused_m = ^in_m;

  assign w_cnt_m1 = CNT_W'(r_cnt - CNT_W'(1));
  // Current ladder bit e[cnt-1]; stable through ISSUE and WAIT since cnt only moves on completion
  assign w_bit    = |(r_e & (WIDTH'(1) << w_cnt_m1));

`ifdef MONT_LADDER_SKIP_ZERO_EN
  logic [CNT_W-1:0] w_cnt_m2;
  logic             w_bit_nx;
  assign w_cnt_m2 = CNT_W'(r_cnt - CNT_W'(2));
  assign w_bit_nx = |(r_e & (WIDTH'(1) << w_cnt_m2));
`endif

  // Results may arrive in different cycles; use the live value on the done cycle
  assign w_res0 = mul.mul_done[CH_MUL] ? mul.mul_res0 : r_res0;
  assign w_res1 = mul.mul_done[CH_SQR] ? mul.mul_res1 : r_res1;

  mont_done_latch #(.N_CH(N_CH)) u_done_latch (
    .clk          (clk),
    .resetn       (resetn),
    .i_clr        (|r_mul_start),
    .i_done       (mul.mul_done),
    .i_mask       (w_wait_mask),
    .o_all_done_c (w_all_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_n;
  end

  // Next state and datapath controls
  always_comb begin
    w_state_n    = r_state;
    w_load       = 1'b0;
    w_err        = 1'b0;
    w_init_r1    = 1'b0;
    w_round      = 1'b0;
    w_final      = 1'b0;
    w_dec        = 1'b0;
    w_issue_mask = '0;
    w_wait_mask  = '0;
    w_wait_mask[CH_MUL] = 1'b1;
    if (r_state == ST_WAIT) w_wait_mask[CH_SQR] = 1'b1;

    if (abort) begin
      w_state_n = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (in_lene > ELEN_W'(WIDTH)) begin
              w_err = 1'b1;
            end else begin
              w_load    = 1'b1;
              w_state_n = ST_ISSUE_INIT;
            end
          end
        end
        ST_ISSUE_INIT: begin
`ifdef MONT_LADDER_SKIP_ZERO_EN
          if (r_cnt != '0 && !w_bit) w_state_n = ST_SKIP;
          else
`endif
          w_state_n = ST_WAIT_INIT;
        end
`ifdef MONT_LADDER_SKIP_ZERO_EN
        // Leading zeros leave (R0, R1) unchanged; the init multiply runs meanwhile
        ST_SKIP: begin
          w_dec = 1'b1;
          if (w_cnt_m1 == '0 || w_bit_nx) w_state_n = ST_WAIT_INIT;
        end
`endif
        ST_WAIT_INIT: begin
          if (w_all_done) begin
            w_init_r1 = 1'b1;
            w_state_n = (r_cnt != '0) ? ST_ISSUE : ST_FINAL_ISSUE;
          end
        end
        ST_ISSUE: w_state_n = ST_WAIT;
        ST_WAIT: begin
          if (w_all_done) begin
            w_round   = 1'b1;
            w_state_n = (w_cnt_m1 != '0) ? ST_ISSUE : ST_FINAL_ISSUE;
          end
        end
        ST_FINAL_ISSUE: w_state_n = ST_FINAL_WAIT;
        ST_FINAL_WAIT: begin
          if (w_all_done) begin
            w_final   = 1'b1;
            w_state_n = ST_DONE;
          end
        end
        ST_DONE: w_state_n = ST_IDLE;
        default: w_state_n = ST_IDLE;
      endcase
    end

    // Issue pulses are registered so they coincide with the issue state
    case (w_state_n)
      ST_ISSUE_INIT, ST_FINAL_ISSUE: w_issue_mask[CH_MUL] = 1'b1;
      ST_ISSUE: begin
        w_issue_mask[CH_MUL] = 1'b1;
        w_issue_mask[CH_SQR] = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand routing; sourced only from registers that hold still until completion
  always_comb begin
    w_a0 = r_r0;
    w_b0 = r_r1;
    w_sq = w_bit ? r_r1 : r_r0;
    case (r_state)
      ST_ISSUE_INIT, ST_SKIP, ST_WAIT_INIT: begin
        w_a0 = r_x;
        w_b0 = r_r2;
      end
      ST_FINAL_ISSUE, ST_FINAL_WAIT: w_b0 = WIDTH'(1);
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_x         <= '0;
      r_e         <= '0;
      r_r2        <= '0;
      r_r0        <= '0;
      r_r1        <= '0;
      r_res0      <= '0;
      r_res1      <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_mul_start <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mul_start <= w_issue_mask;
      r_busy      <= (w_state_n != ST_IDLE);
      r_done      <= (w_state_n == ST_DONE);
      r_err       <= w_err;
      if (mul.mul_done[CH_MUL]) r_res0 <= mul.mul_res0;
      if (mul.mul_done[CH_SQR]) r_res1 <= mul.mul_res1;
      if (w_load) begin
        r_x   <= in_x;
        r_e   <= in_e;
        r_r2  <= in_r2;
        r_r0  <= in_r;
        r_cnt <= CNT_W'(in_lene);
      end
      if (w_init_r1) r_r1 <= w_res0;
      if (w_dec)     r_cnt <= w_cnt_m1;
      if (w_round) begin
        r_cnt <= w_cnt_m1;
        if (w_bit) begin
          r_r0 <= w_res0;
          r_r1 <= w_res1;
        end else begin
          r_r1 <= w_res0;
          r_r0 <= w_res1;
        end
      end
      if (w_final) r_result <= w_res0;
    end
  end

  assign mul.mul_start = r_mul_start;
  assign mul.mul_a0    = w_a0;
  assign mul.mul_b0    = w_b0;
  assign mul.mul_a1    = w_sq;
  assign mul.mul_b1    = w_sq;
  assign result        = r_result;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule

// File: tb/tb_mont_ladder_exp_p.sv
// Bench for mont_ladder_exp_p: WIDTH=16, two behavioural Montgomery multipliers
// with latency L plus per-channel skew, scoreboard of expected result and latency.
module tb_mont_ladder_exp_p;

  localparam int unsigned W  = 16;
  localparam int unsigned EW = 32;
  localparam int unsigned L  = 5;

  logic          clk = 1'b0;
  logic          resetn, start, abort;
  logic [W-1:0]  in_x, in_m, in_e, in_r, in_r2, result;
  logic [EW-1:0] in_lene;
  logic          busy, done, err;

  mont_ladder_exp_p_if #(.WIDTH(W)) mif ();

  mont_ladder_exp_p #(.WIDTH(W), .ELEN_W(EW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .abort   (abort),
    .in_x    (in_x),
    .in_m    (in_m),
    .in_e    (in_e),
    .in_lene (in_lene),
    .in_r    (in_r),
    .in_r2   (in_r2),
    .result  (result),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .mul     (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int unsigned  lat;
    int unsigned  t0;
  } exp_t;

  exp_t         sb[$];
  int unsigned  n_checks = 0, n_errors = 0;
  int unsigned  cyc = 0, busy_cnt = 0, n_done = 0;
  int unsigned  skew0 = 0, skew1 = 0;
  logic [W-1:0] cur_m = 16'd7, last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, b, m);
    logic [63:0] t;
    t = 64'(a) * 64'(b);
    for (int i = 0; i < int'(W); i++) begin
      if (t[0]) t = t + 64'(m);
      t = t >> 1;
    end
    if (t >= 64'(m)) t = t - 64'(m);
    return W'(t);
  endfunction

  function automatic logic [W-1:0] ref_exp(input logic [W-1:0] x, e, m, input int unsigned lene);
    logic [63:0] acc;
    acc = 64'd1 % 64'(m);
    for (int i = int'(lene) - 1; i >= 0; i--) begin
      acc = (acc * acc) % 64'(m);
      if (e[i]) acc = (acc * 64'(x)) % 64'(m);
    end
    return W'(acc);
  endfunction

  // Expected done cycle relative to the start cycle
  function automatic int unsigned ref_lat(input logic [W-1:0] e, input int unsigned lene);
    int unsigned d0, d1, dm, z, st;
    d0 = L + skew0;
    d1 = L + skew1;
    dm = (d0 > d1) ? d0 : d1;
    z  = 0;
`ifdef MONT_LADDER_SKIP_ZERO_EN
    while (z < lene && e[lene - 1 - z] == 1'b0) z++;
`endif
    st = 2 + d0;
    if (z > 0 && 3 + z > st) st = 3 + z;
    return st + (lene - z) * (dm + 1) + d0 + 1;
  endfunction

  // Behavioural multipliers: result a*b*R^-1 mod m, done L+skew cycles after issue
  int unsigned  cnt0 = 0, cnt1 = 0;
  logic [W-1:0] a0c, b0c, a1c, b1c;

  always @(posedge clk) begin
    mif.mul_done <= '0;
    if (mif.mul_start[0]) begin
      a0c  <= mif.mul_a0;
      b0c  <= mif.mul_b0;
      cnt0 <= L + skew0 - 1;
    end else if (cnt0 != 0) begin
      cnt0 <= cnt0 - 1;
      if (cnt0 == 1) begin
        mif.mul_done[0] <= 1'b1;
        mif.mul_res0    <= mont(a0c, b0c, cur_m);
      end
    end
    if (mif.mul_start[1]) begin
      a1c  <= mif.mul_a1;
      b1c  <= mif.mul_b1;
      cnt1 <= L + skew1 - 1;
    end else if (cnt1 != 0) begin
      cnt1 <= cnt1 - 1;
      if (cnt1 == 1) begin
        mif.mul_done[1] <= 1'b1;
        mif.mul_res1    <= mont(a1c, b1c, cur_m);
      end
    end
  end

  // Output monitor
  always @(negedge clk) begin
    exp_t ex;
    if (busy) busy_cnt++;
    if (busy && mif.mul_done[0] === 1'b1) begin
      check("opnd_a0_held", mif.mul_a0, a0c);
      check("opnd_b0_held", mif.mul_b0, b0c);
    end
    if (busy && mif.mul_done[1] === 1'b1) begin
      check("opnd_a1_held", mif.mul_a1, a1c);
      check("opnd_b1_held", mif.mul_b1, b1c);
    end
    if (done) begin
      n_done++;
      check("done_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        ex = sb.pop_front();
        check("result", result, ex.res);
        check("latency", cyc - ex.t0, ex.lat);
        check("busy_cycles", busy_cnt, ex.lat);
        last_exp = ex.res;
      end
    end
  end

  task automatic do_start(input logic [W-1:0] x, m, e, input int unsigned lene, input bit accept);
    logic [63:0] r;
    @(negedge clk);
    r       = 64'h1_0000 % 64'(m);
    in_x    = x;
    in_m    = m;
    in_e    = e;
    in_lene = EW'(lene);
    in_r    = W'(r);
    in_r2   = W'((r * r) % 64'(m));
    start   = 1'b1;
    if (accept) begin
      cur_m    = m;
      busy_cnt = 0;
      sb.push_back('{res: ref_exp(x, e, m, lene), lat: ref_lat(e, lene), t0: cyc});
    end
    @(negedge clk);
    start   = 1'b0;
    in_x    = W'($urandom);
    in_e    = W'($urandom);
    in_r    = W'($urandom);
    in_r2   = W'($urandom);
    in_lene = EW'($urandom_range(0, 16));
  endtask

  task automatic wait_done(input int unsigned max_cyc);
    int unsigned n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  int unsigned  snap;
  logic [W-1:0] mods[8] = '{16'd7, 16'd11, 16'd13, 16'd101, 16'd251, 16'd4093, 16'd32749, 16'd65521};

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    in_x = '0; in_m = '0; in_e = '0; in_r = '0; in_r2 = '0; in_lene = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mul_start", mif.mul_start, 0);

    // Basic ladder and short exponent lengths
    do_start(16'd3, 16'd7, 16'd5, 3, 1'b1);
    wait_done(200);
    do_start(16'd3, 16'd7, 16'd5, 0, 1'b1);
    wait_done(200);
    do_start(16'd3, 16'd7, 16'd1, 1, 1'b1);
    wait_done(200);

    // Length beyond WIDTH is refused
    do_start(16'd3, 16'd7, 16'd5, 17, 1'b0);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_mul_start", mif.mul_start, 0);
    @(negedge clk);
    check("err_one_cycle", err, 0);
    check("err_busy_after", busy, 0);
    check("err_result_kept", result, last_exp);

    // Start while busy is ignored
    snap = n_done;
    do_start(16'd3, 16'd7, 16'd5, 3, 1'b1);
    repeat (8) @(negedge clk);
    do_start(16'd2, 16'd7, 16'd3, 2, 1'b0);
    wait_done(200);
    repeat (60) @(negedge clk);
    check("single_done", n_done - snap, 1);
    check("busy_start_result", result, 16'd5);

    // Abort during the WAIT of ladder round 2
    do_start(16'd3, 16'd7, 16'd6, 3, 1'b1);
    repeat (14) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sb.delete();
    snap = n_done;
    check("abort_busy", busy, 0);
    check("abort_mul_start", mif.mul_start, 0);
    repeat (30) @(negedge clk);
    check("abort_no_done", n_done - snap, 0);
    check("abort_result_kept", result, 16'd5);
    do_start(16'd3, 16'd7, 16'd6, 3, 1'b1);
    wait_done(200);

    // Square channel finishes three cycles after the product channel
    skew1 = 3;
    do_start(16'd3, 16'd7, 16'd5, 3, 1'b1);
    wait_done(300);
    skew1 = 0;

    // Leading zero exponent bits
    do_start(16'd3, 16'd7, 16'd5, 8, 1'b1);
    wait_done(300);

    // Reset in the middle of a run
    do_start(16'd4, 16'd11, 16'd7, 4, 1'b1);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    sb.delete();
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    repeat (20) @(negedge clk);

    // Mixed moduli, exponents, lengths and skews (first one at full length)
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] m;
      m     = mods[i];
      skew0 = $urandom_range(0, 3);
      skew1 = $urandom_range(0, 3);
      do_start(W'($urandom % 32'(m)), m, W'($urandom), (i == 0) ? 16 : $urandom_range(0, 16), 1'b1);
      wait_done(600);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
